ej32_mem_arb: RTL
=================

# ej32_mem_arb

Two-port arbiter that shares the eJ32 byte-wide memory bus between the core (opcode fetch and load/store unit) and a host port (dictionary/ROM loader and debug memory dumper). Each cycle it grants at most one byte access, keeps ownership sticky to avoid needless switching, and bounds starvation with a wait counter. A host lock holds the bus for an uninterrupted burst. It routes the memory's one-cycle-latency read data back to the issuer.

## Interface
- ASZ, 17, byte address width
- DSZ, 8, data width
- MAX_WAIT, 16, cycles a blocked requester waits before it forces a switch (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (1=write, 0=read)
- c_a  in  ASZ  core byte address
- c_vo  in  DSZ  core write data
- c_gnt  out  1  core access issued this cycle
- c_vld  out  1  core read data valid
- c_vi  out  DSZ  core read data
- h_req  in  1  host access request
- h_we  in  1  host write enable
- h_lock  in  1  host burst lock, honoured only while host owns the bus
- h_a  in  ASZ  host byte address
- h_vo  in  DSZ  host write data
- h_gnt  out  1  host access issued this cycle
- h_vld  out  1  host read data valid
- h_vi  out  DSZ  host read data
- m_en  out  1  memory cycle enable
- m_we  out  1  memory write enable
- m_a  out  ASZ  memory address
- m_vo  out  DSZ  memory write data
- m_vi  in  DSZ  memory read data, valid the cycle after a read is enabled
- own  out  2  current owner: 0=IDLE, 1=CORE, 2=HOST

## Operation
- Owner FSM has states IDLE, CORE and HOST. `own` reflects the state register.
- starve = (cnt ≥ MAX_WAIT).
- The grant is combinational from the state, c_req, h_req, h_lock and starve:
  - IDLE: if h_req, grant host; else if c_req, grant core; else grant none.
  - CORE: if c_req and not (h_req and starve), grant core; else if h_req, grant host; else grant none.
  - HOST: if h_req and (h_lock or not starve), grant host; else if c_req, grant core; else grant none.
- c_gnt and h_gnt are one-hot or zero. Never both.
- The next state is the granted port, or IDLE if there is no grant.
- Memory mux:
  - m_en = c_gnt | h_gnt.
  - m_we, m_a and m_vo come from the granted port.
  - With no grant, m_we=0 and m_a/m_vo hold their last value (no X).
- Wait counter cnt, width clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, when a port requests, is not granted, and the other port is granted.
  - Otherwise it clears.
- Read return:
  - On a granted read, register tag ∈ {core, host}.
  - Next cycle, assert the tagged x_vld for one cycle with x_vi = m_vi.
  - Writes produce no vld.
  - x_vi holds its last value when x_vld=0.
- h_lock with HOST owner: the host is never preempted, even when starve is set. h_lock in any other state has no effect.
- Simultaneous requests from IDLE: the host wins.

## Timing
- Reset (synchronous, at the clk edge with rst=1):
  - state=IDLE, cnt=0, tag cleared.
  - c_vld=h_vld=0 and c_vi=h_vi=0.
  - m_we=0, m_a=0, m_vo=0.
  - With rst=1, grants are forced to 0, so m_en=0.
- Grant latency is 0 cycles: the request and the grant happen in the same cycle.
- Read data latency is 1 cycle after the grant, so back-to-back reads stream 1 byte/cycle.
- An ownership switch costs no idle cycle. The new owner is granted in the cycle the FSM decides.
- Reset mid-read: a read granted in the reset cycle is discarded, and vld stays 0 the next cycle.
- A switch from a port with an outstanding read is allowed. Its data still returns to the original issuer via the tag.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with c_req=h_req=1.
  - Required: c_gnt=h_gnt=0, m_en=0, own=0, c_vld=h_vld=0. After release, host granted first, own=2 the next cycle.
- Core streaming:
  - Stimulus: h_req=0; core reads 0x1000..0x1003 on consecutive cycles, memory preloaded 0x11,0x22,0x33,0x44.
  - Required: c_gnt=1 on 4 cycles; c_vld=1 on the 4 following cycles with c_vi 0x11,0x22,0x33,0x44; h_vld stays 0.
- Starvation switch:
  - Stimulus: CORE owns with c_req held; h_req asserted at cycle T, MAX_WAIT=16.
  - Required: h_gnt=0 for T..T+15; h_gnt=1 at T+16; own=2 from T+17.
- Host lock:
  - Stimulus: HOST owns with h_lock=1 and writes 0x1400..0x1427 (40 bytes) while c_req=1 throughout.
  - Required: all 40 host grants uninterrupted, c_gnt=0 during the burst; the core is granted the cycle h_req drops.
- Tag routing across a switch:
  - Stimulus: host reads 0x0000 (=0xAB) at cycle T, h_req drops, core reads 0x0001 (=0xCD) at T+1.
  - Required: h_vld=1 with h_vi=0xAB at T+1; c_vld=1 with c_vi=0xCD at T+2; no cross-delivery.
- Reset mid-read:
  - Stimulus: core read granted in the same cycle rst=1.
  - Required: c_vld=0 the next cycle; own=0.

Source files
------------

// File: rtl/ej32_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ej32_mem_arb
// Purpose  : Shares the eJ32 byte-wide memory bus between the core port and a
//            host (loader/debug) port. It issues at most one access per cycle.
//            Ownership is sticky. A wait counter bounds starvation, and a host
//            lock keeps the bus for an uninterrupted burst. Read data returns
//            one cycle after the grant and is steered back to the issuer by a
//            registered tag.
// Ports    : clk, rst                        clock, sync active-high reset
//            c_req/c_we/c_a/c_vo             core request side
//            c_gnt/c_vld/c_vi                core grant and read return
//            h_req/h_we/h_lock/h_a/h_vo      host request side
//            h_gnt/h_vld/h_vi                host grant and read return
//            m_en/m_we/m_a/m_vo/m_vi         memory bus (1-cycle read latency)
//            own                             owner: 0=IDLE 1=CORE 2=HOST
// Revision : 1.0  initial release
// ============================================================================
module ej32_mem_arb #(
    parameter int ASZ      = 17,
    parameter int DSZ      = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           c_req,
    input  logic           c_we,
    input  logic [ASZ-1:0] c_a,
    input  logic [DSZ-1:0] c_vo,
    output logic           c_gnt,
    output logic           c_vld,
    output logic [DSZ-1:0] c_vi,
    input  logic           h_req,
    input  logic           h_we,
    input  logic           h_lock,
    input  logic [ASZ-1:0] h_a,
    input  logic [DSZ-1:0] h_vo,
    output logic           h_gnt,
    output logic           h_vld,
    output logic [DSZ-1:0] h_vi,
    output logic           m_en,
    output logic           m_we,
    output logic [ASZ-1:0] m_a,
    output logic [DSZ-1:0] m_vo,
    input  logic [DSZ-1:0] m_vi,
    output logic [1:0]     own
);

    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_HOST = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic           w_starve;
    logic           w_c_gnt;
    logic           w_h_gnt;
    logic           w_blocked;
    logic           r_c_pend;
    logic           r_h_pend;
    logic [DSZ-1:0] r_c_vi;
    logic [DSZ-1:0] r_h_vi;
    logic [ASZ-1:0] r_m_a;
    logic [DSZ-1:0] r_m_vo;

    assign w_starve = (r_cnt >= MAX_CNT);

    // Grant / next-state logic
    always_comb begin
        w_c_gnt     = 1'b0;
        w_h_gnt     = 1'b0;
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_CORE: begin
                if (c_req && !(h_req && w_starve)) w_c_gnt = 1'b1;
                else if (h_req)                    w_h_gnt = 1'b1;
            end
            ST_HOST: begin
                // Lock only matters once the host already owns the bus.
                if (h_req && (h_lock || !w_starve)) w_h_gnt = 1'b1;
                else if (c_req)                     w_c_gnt = 1'b1;
            end
            default: begin
                // Simultaneous requests from idle: host wins.
                if (h_req)      w_h_gnt = 1'b1;
                else if (c_req) w_c_gnt = 1'b1;
            end
        endcase
        if (rst) begin
            w_c_gnt = 1'b0;
            w_h_gnt = 1'b0;
        end
        if (w_h_gnt)      w_state_nxt = ST_HOST;
        else if (w_c_gnt) w_state_nxt = ST_CORE;
    end

    // A requester is only "waiting" while the bus is busy with the other port.
    assign w_blocked = (c_req && !w_c_gnt && w_h_gnt) ||
                       (h_req && !w_h_gnt && w_c_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_c_pend <= 1'b0;
            r_h_pend <= 1'b0;
            r_c_vi   <= '0;
            r_h_vi   <= '0;
            r_m_a    <= '0;
            r_m_vo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_blocked) r_cnt <= (r_cnt == MAX_CNT) ? r_cnt : r_cnt + 1'b1;
            else           r_cnt <= '0;
            // Tag of the read in flight; data returns next cycle.
            r_c_pend <= w_c_gnt && !c_we;
            r_h_pend <= w_h_gnt && !h_we;
            if (r_c_pend) r_c_vi <= m_vi;
            if (r_h_pend) r_h_vi <= m_vi;
            if (w_c_gnt) begin
                r_m_a  <= c_a;
                r_m_vo <= c_vo;
            end else if (w_h_gnt) begin
                r_m_a  <= h_a;
                r_m_vo <= h_vo;
            end
        end
    end

    assign c_gnt = w_c_gnt;
    assign h_gnt = w_h_gnt;
    assign m_en  = w_c_gnt | w_h_gnt;
    assign m_we  = w_c_gnt ? c_we : (w_h_gnt ? h_we : 1'b0);
    assign m_a   = w_c_gnt ? c_a  : (w_h_gnt ? h_a  : r_m_a);
    assign m_vo  = w_c_gnt ? c_vo : (w_h_gnt ? h_vo : r_m_vo);

    // Return data passes straight through on the valid cycle, then holds.
    assign c_vld = r_c_pend;
    assign h_vld = r_h_pend;
    assign c_vi  = r_c_pend ? m_vi : r_c_vi;
    assign h_vi  = r_h_pend ? m_vi : r_h_vi;
    assign own   = r_state;

endmodule
`default_nettype wire
